// File: rtl/rega_word_loader.sv
// Byte-to-word feeder for the 32-bit load register: packs a little-endian byte stream
// into DATA_W-bit words and strobes loadA for one cycle per completed word.
module rega_word_loader #(
    parameter int DATA_W      = 32,
    parameter int BYTE_W      = 8,
    parameter int TIMEOUT_CYC = 16,
    parameter int CNT_W       = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_valid,
    input  logic [BYTE_W-1:0] byte_data,
    input  logic              byte_last,
    output logic              byte_ready,
    input  logic              flush,
    output logic              loadA,
    output logic [DATA_W-1:0] dataAin,
    output logic [CNT_W-1:0]  word_count,
    output logic              partial_drop,
    output logic [1:0]        dbg_state_o
);

    localparam int N     = DATA_W / BYTE_W;
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int TW    = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
    localparam int TO_M1 = (TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_LOAD    = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic [KW-1:0]     k_q, k_d;
    logic [TW-1:0]     idle_q, idle_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              drop_q, drop_d;

    logic              accept;
    logic              complete;
    logic              timeout_hit;
    logic [DATA_W-1:0] packed_word;

    // Handshake: a byte transfers on a rising edge where byte_valid && byte_ready;
    // byte_ready depends only on state and flush, never on byte_valid.
    assign accept   = byte_valid && byte_ready;
    assign complete = accept && (byte_last || (k_q == KW'(N - 1)));
    assign timeout_hit = (TIMEOUT_CYC > 0) && (state_q == ST_COLLECT) && !accept
                         && !flush && (idle_q == TW'(TO_M1));

    always_comb begin
        packed_word = buf_q;
        for (int i = 0; i < N; i++) begin
            if (k_q == KW'(i)) begin
                packed_word[i*BYTE_W +: BYTE_W] = byte_data;
            end
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE, ST_COLLECT: begin
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (complete) begin
                    state_d = ST_LOAD;
                end else if (accept) begin
                    state_d = ST_COLLECT;
                end else if (timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end
            ST_LOAD: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        loadA       = (state_q == ST_LOAD);
        byte_ready  = rst_n && (state_q != ST_LOAD) && !flush;
        dbg_state_o = state_q;
    end

    // Datapath next values; the word is latched into data_q on the edge that enters LOAD
    always_comb begin
        k_d    = k_q;
        buf_d  = buf_q;
        idle_d = idle_q;
        data_d = data_q;
        cnt_d  = cnt_q;
        drop_d = 1'b0;
        if (state_q != ST_LOAD) begin
            if (flush) begin
                k_d    = '0;
                buf_d  = '0;
                idle_d = '0;
                drop_d = (k_q != '0);
            end else if (accept) begin
                idle_d = '0;
                if (complete) begin
                    data_d = packed_word;
                    cnt_d  = cnt_q + CNT_W'(1);
                    k_d    = '0;
                    buf_d  = '0;
                end else begin
                    buf_d = packed_word;
                    k_d   = k_q + KW'(1);
                end
            end else if (timeout_hit) begin
                k_d    = '0;
                buf_d  = '0;
                idle_d = '0;
                drop_d = 1'b1;
            end else if ((TIMEOUT_CYC > 0) && (state_q == ST_COLLECT)) begin
                idle_d = idle_q + TW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k_q    <= '0;
            idle_q <= '0;
            buf_q  <= '0;
            data_q <= '0;
            cnt_q  <= '0;
            drop_q <= 1'b0;
        end else begin
            k_q    <= k_d;
            idle_q <= idle_d;
            buf_q  <= buf_d;
            data_q <= data_d;
            cnt_q  <= cnt_d;
            drop_q <= drop_d;
        end
    end

    assign dataAin      = data_q;
    assign word_count   = cnt_q;
    assign partial_drop = drop_q;

endmodule

// File: tb/tb_rega_word_loader.sv
// Bench for rega_word_loader: directed scenarios plus random traffic against a
// byte-queue reference model; a second instance with a 2-bit counter exercises wrap.
module tb_rega_word_loader;

    localparam int N  = 4;
    localparam int TO = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        byte_valid = 1'b0;
    logic [7:0]  byte_data = 8'h00;
    logic        byte_last = 1'b0;
    logic        flush = 1'b0;

    logic        byte_ready, loadA, partial_drop;
    logic [31:0] dataAin;
    logic [15:0] word_count;
    logic [1:0]  dbg_state;

    logic        byte_ready_w, loadA_w, partial_drop_w;
    logic [31:0] dataAin_w;
    logic [1:0]  word_count_w;
    logic [1:0]  dbg_state_w;

    // Clock / reset
    always #5 clk = ~clk;

    rega_word_loader #(.DATA_W(32), .BYTE_W(8), .TIMEOUT_CYC(TO), .CNT_W(16)) u_dut (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(byte_ready), .flush(flush), .loadA(loadA),
        .dataAin(dataAin), .word_count(word_count), .partial_drop(partial_drop),
        .dbg_state_o(dbg_state)
    );

    rega_word_loader #(.DATA_W(32), .BYTE_W(8), .TIMEOUT_CYC(TO), .CNT_W(2)) u_dut_w (
        .clk(clk), .rst_n(rst_n), .byte_valid(byte_valid), .byte_data(byte_data),
        .byte_last(byte_last), .byte_ready(byte_ready_w), .flush(flush), .loadA(loadA_w),
        .dataAin(dataAin_w), .word_count(word_count_w), .partial_drop(partial_drop_w),
        .dbg_state_o(dbg_state_w)
    );

    // Reference model state
    logic [7:0]  pend[$];
    logic [31:0] exp_q[$];
    int          idle_cnt = 0;
    int          exp_cnt = 0;
    logic        exp_load = 1'b0;
    logic        exp_drop = 1'b0;
    logic [31:0] exp_data = 32'h0;

    int chk_cnt = 0;
    int err_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        idle_cnt = 0;
        exp_cnt  = 0;
        exp_load = 1'b0;
        exp_drop = 1'b0;
        exp_data = 32'h0;
    endtask

    // One cycle of the reference: bytes queue up, a word forms on byte_last or the N-th byte
    task automatic model_step();
        logic        nl, nd;
        logic [31:0] w;
        nl = 1'b0;
        nd = 1'b0;
        if (!exp_load) begin
            if (flush) begin
                if (pend.size() > 0) nd = 1'b1;
                pend.delete();
                idle_cnt = 0;
            end else if (byte_valid) begin
                pend.push_back(byte_data);
                idle_cnt = 0;
                if (byte_last || pend.size() == N) begin
                    w = 32'h0;
                    foreach (pend[i]) w = w | (32'(pend[i]) << (8 * i));
                    exp_data = w;
                    exp_q.push_back(w);
                    exp_cnt++;
                    nl = 1'b1;
                    pend.delete();
                end
            end else if (pend.size() > 0) begin
                idle_cnt++;
                if (idle_cnt == TO) begin
                    nd = 1'b1;
                    pend.delete();
                    idle_cnt = 0;
                end
            end
        end
        exp_load = nl;
        exp_drop = nd;
    endtask

    task automatic check_outputs();
        check("loadA", 32'(loadA), 32'(exp_load));
        check("partial_drop", 32'(partial_drop), 32'(exp_drop));
        check("byte_ready", 32'(byte_ready), 32'(!exp_load && !flush));
        check("dataAin", dataAin, exp_data);
        check("word_count", 32'(word_count), 32'(exp_cnt % 65536));
        check("word_count_w", 32'(word_count_w), 32'(exp_cnt % 4));
        if (loadA) begin
            if (exp_q.size() == 0) check("load_unexpected", 32'(loadA), 32'h0);
            else check("load_word", dataAin, exp_q.pop_front());
        end
    endtask

    // Driver: apply inputs just after posedge, check and advance model on negedge
    task automatic cycle(input logic v, input logic [7:0] d, input logic l, input logic f);
        byte_valid = v;
        byte_data  = d;
        byte_last  = l;
        flush      = f;
        @(negedge clk);
        check_outputs();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < N; i++) cycle(1'b1, w[8*i +: 8], 1'b0, 1'b0);
    endtask

    task automatic async_reset_check();
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_loadA", 32'(loadA), 32'h0);
        check("rst_dataAin", dataAin, 32'h0);
        check("rst_word_count", 32'(word_count), 32'h0);
        check("rst_partial_drop", 32'(partial_drop), 32'h0);
        check("rst_byte_ready", 32'(byte_ready), 32'h0);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
        flush      = 1'b0;
        model_reset();
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc;
        int   idx;

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check("init_byte_ready", 32'(byte_ready), 32'h0);
        check("init_loadA", 32'(loadA), 32'h0);
        check("init_dataAin", dataAin, 32'h0);
        check("init_word_count", 32'(word_count), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Four bytes back to back
        send_word(32'h44332211);
        check("tp1_loadA", 32'(loadA), 32'h1);
        check("tp1_data", dataAin, 32'h44332211);
        check("tp1_count", 32'(word_count), 32'h1);
        check("tp1_ready", 32'(byte_ready), 32'h0);
        idle(2);

        // byte_valid held for 8 bytes; stream stalls during each LOAD
        idx = 1;
        while (idx <= 8) begin
            acc = !exp_load;
            cycle(1'b1, 8'(idx), 1'b0, 1'b0);
            if (acc) idx++;
        end
        check("tp2_data", dataAin, 32'h08070605);
        check("tp2_count", 32'(word_count), 32'h3);
        idle(2);

        // Early completion with byte_last
        cycle(1'b1, 8'hAA, 1'b0, 1'b0);
        cycle(1'b1, 8'hBB, 1'b1, 1'b0);
        check("tp3_loadA", 32'(loadA), 32'h1);
        check("tp3_data", dataAin, 32'h0000BBAA);
        idle(1);

        // Single byte with byte_last from IDLE
        cycle(1'b1, 8'h3C, 1'b1, 1'b0);
        check("one_byte_data", dataAin, 32'h0000003C);
        idle(1);

        // Timeout drops a partial byte
        cycle(1'b1, 8'h5A, 1'b0, 1'b0);
        idle(TO);
        check("tp4_drop", 32'(partial_drop), 32'h1);
        check("tp4_noload", 32'(loadA), 32'h0);
        send_word(32'h04030201);
        check("tp4_data", dataAin, 32'h04030201);
        idle(1);

        // Flush after two bytes
        cycle(1'b1, 8'h12, 1'b0, 1'b0);
        cycle(1'b1, 8'h34, 1'b0, 1'b0);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("fl1_drop", 32'(partial_drop), 32'h1);
        check("fl1_noload", 32'(loadA), 32'h0);
        idle(1);

        // Flush during LOAD is ignored
        send_word(32'hCAFEF00D);
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        check("fl2_nodrop", 32'(partial_drop), 32'h0);
        idle(1);

        // Byte offered together with flush is not taken
        cycle(1'b1, 8'h77, 1'b0, 1'b1);
        send_word(32'h89ABCDEF);
        check("fl3_data", dataAin, 32'h89ABCDEF);
        idle(1);

        // Async reset mid-word, then a clean word and counter wrap on the narrow instance
        for (int i = 0; i < 3; i++) cycle(1'b1, 8'(8'hE0 + i), 1'b0, 1'b0);
        async_reset_check();
        send_word(32'hEFBEADDE);
        check("rst_word_data", dataAin, 32'hEFBEADDE);
        check("rst_word_count", 32'(word_count), 32'h1);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            send_word($urandom);
            idle(1);
        end
        check("wrap_count_w", 32'(word_count_w), 32'h0);
        check("wrap_count", 32'(word_count), 32'h4);

        // Random traffic
        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 99) < 3) idle($urandom_range(12, 20));
            cycle($urandom_range(0, 99) < 70, 8'($urandom_range(0, 255)),
                  $urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0);
        end
        idle(3);
        check("final_queue_empty", 32'(exp_q.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
